// File: rtl/biss_sample_packer.sv
// biss_sample_packer: frames decoded BiSS-C samples into a 32-bit AXI4-Stream.
// Each sample becomes two beats (timestamp, status/position). Packets carry a
// programmable number of samples and end with tlast. A sample FIFO absorbs
// downstream backpressure; samples arriving while it is full are dropped and
// counted.
module biss_sample_packer #(
    parameter int POS_W      = 26,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             axis_aclk,
    input  logic             axis_aresetn,
    input  logic             en,
    input  logic [15:0]      frame_len,
    input  logic             sample_valid,
    input  logic [POS_W-1:0] sample_pos,
    input  logic             sample_err,
    input  logic             sample_warn,
    input  logic             sample_crc_err,
    input  logic             clr_stat,
    output logic             m_axis_tvalid,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tlast,
    output logic [3:0]       m_axis_tkeep,
    input  logic             m_axis_tready,
    output logic [15:0]      drop_cnt,
    output logic             overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // entry = {ts[31:0], err, warn, crc_err, seq[2:0], pos}
    localparam int EW = 38 + POS_W;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2
    } state_t;

    // Builds the status/position beat from the low part of a FIFO entry.
    function automatic logic [31:0] word1_f(input logic [POS_W+5:0] e);
        word1_f = {e[POS_W+5:POS_W], 26'(e[POS_W-1:0])};
    endfunction

    logic [31:0]   ts_r;
    logic [2:0]    seq_r;
    logic [EW-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] rd_nxt_s;
    logic [AW:0]   cnt_r;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic          hs_s;
    logic [EW-1:0] entry_s;
    logic [EW-1:0] head_s;
    logic [31:0]   next_ts_s;

    state_t        state_r;
    state_t        state_s;
    logic [31:0]   tdata_r;
    logic [31:0]   tdata_s;
    logic          tvalid_r;
    logic          tvalid_s;
    logic          tlast_r;
    logic          tlast_s;
    logic [15:0]   pkt_cnt_r;
    logic [15:0]   pkt_cnt_s;
    logic [15:0]   len_r;
    logic [15:0]   len_s;
    logic [15:0]   len_eff_s;
    logic [16:0]   done_s;
    logic          last_s;
    logic [15:0]   drop_cnt_r;
    logic          overflow_r;

    assign hs_s     = tvalid_r & m_axis_tready;
    assign pop_s    = (state_r == ST_W1) & hs_s;
    assign full_s   = (cnt_r == DEPTH_C);
    // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
    assign push_s   = sample_valid & en & (~full_s | pop_s);
    assign drop_s   = sample_valid & en & full_s & ~pop_s;
    assign entry_s  = {ts_r, sample_err, sample_warn, sample_crc_err, seq_r, sample_pos};
    assign rd_nxt_s = rd_ptr_r + AW'(1'b1);
    assign head_s   = mem_r[rd_ptr_r];
    assign next_ts_s = mem_r[rd_nxt_s][EW-1:EW-32];

    // tlast decision for the word1 about to be loaded: packet length reached,
    // or capture disabled with this sample the last one held (flush).
    assign len_eff_s = (len_r == 16'd0) ? 16'd1 : len_r;
    assign done_s    = {1'b0, pkt_cnt_r} + 17'd1;
    assign last_s    = (done_s >= {1'b0, len_eff_s}) | (~en & (cnt_r == ONE_C));

    // Free-running capture timestamp.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            ts_r <= 32'd0;
        end else begin
            ts_r <= ts_r + 32'd1;
        end
    end

    // Sample FIFO storage; contents need no reset since pointers gate reads.
    always_ff @(posedge axis_aclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // FIFO pointers, occupancy and per-sample sequence number.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            seq_r    <= 3'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
                seq_r    <= seq_r + 3'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_nxt_s;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + ONE_C;
                2'b01:   cnt_r <= cnt_r - ONE_C;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Drop statistics; a clear coinciding with a drop leaves that drop counted.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            drop_cnt_r <= 16'd0;
            overflow_r <= 1'b0;
        end else if (clr_stat) begin
            drop_cnt_r <= drop_s ? 16'd1 : 16'd0;
            overflow_r <= drop_s;
        end else if (drop_s) begin
            if (drop_cnt_r != 16'hFFFF) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
            overflow_r <= 1'b1;
        end
    end

    // Output FSM state and output/packet registers.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_r   <= ST_IDLE;
            tdata_r   <= 32'd0;
            tvalid_r  <= 1'b0;
            tlast_r   <= 1'b0;
            pkt_cnt_r <= 16'd0;
            len_r     <= 16'd1;
        end else begin
            state_r   <= state_s;
            tdata_r   <= tdata_s;
            tvalid_r  <= tvalid_s;
            tlast_r   <= tlast_s;
            pkt_cnt_r <= pkt_cnt_s;
            len_r     <= len_s;
        end
    end

    // Output FSM next state: word0 -> word1 per sample, back-to-back when data is queued.
    always_comb begin
        state_s   = state_r;
        tdata_s   = tdata_r;
        tvalid_s  = tvalid_r;
        tlast_s   = tlast_r;
        pkt_cnt_s = pkt_cnt_r;
        len_s     = len_r;
        case (state_r)
            ST_IDLE: begin
                if (cnt_r != '0) begin
                    tdata_s  = head_s[EW-1:EW-32];
                    tvalid_s = 1'b1;
                    tlast_s  = 1'b0;
                    state_s  = ST_W0;
                    if (pkt_cnt_r == 16'd0) begin
                        len_s = frame_len;
                    end else begin
                        len_s = len_r;
                    end
                end else begin
                    tvalid_s = 1'b0;
                    tlast_s  = 1'b0;
                end
            end
            ST_W0: begin
                if (hs_s) begin
                    tdata_s = word1_f(head_s[POS_W+5:0]);
                    tlast_s = last_s;
                    state_s = ST_W1;
                end else begin
                    state_s = ST_W0;
                end
            end
            ST_W1: begin
                if (hs_s) begin
                    pkt_cnt_s = tlast_r ? 16'd0 : (pkt_cnt_r + 16'd1);
                    if (cnt_r > ONE_C) begin
                        tdata_s  = next_ts_s;
                        tvalid_s = 1'b1;
                        tlast_s  = 1'b0;
                        state_s  = ST_W0;
                        if (tlast_r) begin
                            len_s = frame_len;
                        end else begin
                            len_s = len_r;
                        end
                    end else begin
                        tvalid_s = 1'b0;
                        tlast_s  = 1'b0;
                        state_s  = ST_IDLE;
                    end
                end else begin
                    state_s = ST_W1;
                end
            end
            default: begin
                tvalid_s = 1'b0;
                tlast_s  = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tkeep  = 4'hF;
    assign drop_cnt      = drop_cnt_r;
    assign overflow      = overflow_r;

endmodule

// File: tb/tb_biss_sample_packer.sv
// Testbench for biss_sample_packer: directed scenarios plus a randomized phase,
// checked by a scoreboard fed from a behavioural model of the sample stream.
module tb_biss_sample_packer;

    localparam int POS_W = 26;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [15:0]      frame_len = 16'd1;
    logic             sample_valid = 1'b0;
    logic [POS_W-1:0] sample_pos = '0;
    logic             sample_err = 1'b0;
    logic             sample_warn = 1'b0;
    logic             sample_crc_err = 1'b0;
    logic             clr_stat = 1'b0;
    logic             tready = 1'b0;
    logic             tvalid;
    logic [31:0]      tdata;
    logic             tlast;
    logic [3:0]       tkeep;
    logic [15:0]      drop_cnt;
    logic             overflow;

    always #5 clk = ~clk;

    biss_sample_packer #(.POS_W(POS_W), .FIFO_DEPTH(DEPTH)) dut (
        .axis_aclk     (clk),
        .axis_aresetn  (rst_n),
        .en            (en),
        .frame_len     (frame_len),
        .sample_valid  (sample_valid),
        .sample_pos    (sample_pos),
        .sample_err    (sample_err),
        .sample_warn   (sample_warn),
        .sample_crc_err(sample_crc_err),
        .clr_stat      (clr_stat),
        .m_axis_tvalid (tvalid),
        .m_axis_tdata  (tdata),
        .m_axis_tlast  (tlast),
        .m_axis_tkeep  (tkeep),
        .m_axis_tready (tready),
        .drop_cnt      (drop_cnt),
        .overflow      (overflow)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        bit          w1;
    } beat_t;

    // Model state
    beat_t       exp_q[$];
    beat_t       b;
    beat_t       nb;
    int          m_occ = 0;
    int          m_seq = 0;
    int          m_drop = 0;
    bit          m_ovf = 1'b0;
    int          pk = 0;
    int          len = 1;
    bit          exp_last = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;
    bit          dropped;
    int          n_last = 0;
    logic [31:0] tb_ts;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Cycle counter that tracks the capture time base
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= 32'd0;
        else        tb_ts <= tb_ts + 32'd1;
    end

    // Monitor + model: mid-cycle, inputs and outputs are stable for the coming edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_occ = 0; m_seq = 0; m_drop = 0; m_ovf = 1'b0;
            pk = 0; len = 1; exp_last = 1'b0; prev_stall = 1'b0; n_last = 0;
        end else begin
            chk("drop_cnt", {16'd0, drop_cnt}, m_drop);
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            if (prev_stall) begin
                chk("stall_valid", {31'd0, tvalid}, 32'd1);
                chk("stall_data", tdata, prev_data);
                chk("stall_last", {31'd0, tlast}, {31'd0, prev_last});
            end
            if (tvalid && tready) begin
                if (tlast) n_last++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", tdata);
                end else begin
                    b = exp_q.pop_front();
                    chk("tdata", tdata, b.data);
                    chk("tkeep", {28'd0, tkeep}, 32'hF);
                    if (!b.w1) begin
                        chk("tlast_word0", {31'd0, tlast}, 32'd0);
                        if (pk == 0) len = (frame_len == 16'd0) ? 1 : int'(frame_len);
                        exp_last = ((pk + 1) >= len) || (!en && m_occ == 1);
                    end else begin
                        chk("tlast_word1", {31'd0, tlast}, {31'd0, exp_last});
                        pk = exp_last ? 0 : pk + 1;
                        m_occ--;
                    end
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            dropped = 1'b0;
            if (sample_valid && en) begin
                if (m_occ < DEPTH) begin
                    nb.data = tb_ts; nb.w1 = 1'b0;
                    exp_q.push_back(nb);
                    nb.data = {sample_err, sample_warn, sample_crc_err, 3'(m_seq), 26'(sample_pos)};
                    nb.w1 = 1'b1;
                    exp_q.push_back(nb);
                    m_occ++;
                    m_seq = (m_seq + 1) % 8;
                end else begin
                    dropped = 1'b1;
                end
            end
            if (clr_stat) begin
                m_drop = dropped ? 1 : 0;
                m_ovf  = dropped;
            end else if (dropped) begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [POS_W-1:0] pos);
        sample_pos     = pos;
        sample_err     = 1'($urandom);
        sample_warn    = 1'($urandom);
        sample_crc_err = 1'($urandom);
    endtask

    // One-cycle strobe; called just after a rising edge
    task automatic pulse(input logic [POS_W-1:0] pos);
        set_fields(pos);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tvalid) && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
        end
        step();
    endtask

    task automatic do_reset();
        step();
        sample_valid = 1'b0;
        clr_stat = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #500000;
        checks++; errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, tlast}, 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);

        // 1: basic packet with latency check
        frame_len = 16'd3; en = 1'b1; tready = 1'b1;
        step();
        set_fields(26'h12345);
        sample_valid = 1'b1;
        @(negedge clk); chk("lat_n", {31'd0, tvalid}, 32'd0);
        step(); sample_valid = 1'b0;
        @(negedge clk); chk("lat_n1", {31'd0, tvalid}, 32'd0);
        step();
        @(negedge clk); chk("lat_n2", {31'd0, tvalid}, 32'd1);
        repeat (3) step();
        pulse(26'h12346);
        repeat (5) step();
        pulse(26'h12347);
        wait_drain();
        chk("basic_tlast_count", n_last, 32'd1);

        // 2: backpressure, then no bubble between queued samples
        tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse(26'($urandom));
            step();
        end
        repeat (2) step();
        tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); chk("no_bubble", {31'd0, tvalid}, 32'd1);
            step();
        end
        wait_drain();

        // 3: overflow, drain, clear
        tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_fields(26'($urandom));
            sample_valid = 1'b1;
            step();
        end
        sample_valid = 1'b0;
        step();
        @(negedge clk);
        chk("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd4);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        step();
        tready = 1'b1;
        wait_drain();
        clr_stat = 1'b1; step(); clr_stat = 1'b0;
        @(negedge clk);
        chk("clr_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        chk("clr_ovf", {31'd0, overflow}, 32'd0);

        // 5c: clear coinciding with a drop
        step();
        tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            set_fields(26'($urandom));
            sample_valid = 1'b1;
            clr_stat = (i == 16);
            step();
        end
        sample_valid = 1'b0; clr_stat = 1'b0;
        @(negedge clk);
        chk("clr_drop_same_cycle", {16'd0, drop_cnt}, 32'd1);
        chk("clr_drop_ovf", {31'd0, overflow}, 32'd1);
        step();
        tready = 1'b1;
        wait_drain();
        clr_stat = 1'b1; step(); clr_stat = 1'b0;

        // 4: flush on disable
        do_reset();
        frame_len = 16'd8; en = 1'b1; tready = 1'b1;
        pulse(26'h1); repeat (3) step();
        pulse(26'h2); repeat (3) step();
        pulse(26'h3);
        en = 1'b0;
        repeat (2) step();
        pulse(26'h4); step(); pulse(26'h5);
        wait_drain();
        chk("flush_tlast_count", n_last, 32'd1);
        chk("flush_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pulse(26'($urandom)); repeat (2) step();
        end
        wait_drain();
        chk("refill_tlast_count", n_last, 32'd2);

        // 5a: frame_len 0 behaves as 1
        do_reset();
        frame_len = 16'd0; en = 1'b1; tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse(26'($urandom)); repeat (3) step();
        end
        wait_drain();
        chk("len0_tlast_count", n_last, 32'd3);

        // 6: reset while word1 stalled
        do_reset();
        frame_len = 16'd2; en = 1'b1; tready = 1'b0;
        pulse(26'h3FFFFFF);
        repeat (3) step();
        tready = 1'b1; step(); tready = 1'b0;
        @(negedge clk); chk("w1_stalled_valid", {31'd0, tvalid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_valid", {31'd0, tvalid}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        tready = 1'b1;
        pulse(26'h10); repeat (3) step();
        pulse(26'h11);
        wait_drain();
        chk("post_rst_tlast_count", n_last, 32'd1);

        // Randomized phase
        do_reset();
        frame_len = 16'($urandom_range(1, 5));
        for (int c = 0; c < 3000; c++) begin
            set_fields(26'($urandom));
            sample_valid = ($urandom % 3) == 0;
            en           = ($urandom % 10) != 0;
            tready       = (($urandom % 4) != 0) && ((c % 300) >= 60);
            clr_stat     = ($urandom % 50) == 0;
            step();
        end
        sample_valid = 1'b0; clr_stat = 1'b0; en = 1'b1; tready = 1'b1;
        wait_drain();
        chk("random_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
